clos_mid_alloc: RTL
===================

Name: clos_mid_alloc

Overview:
Middle-port allocator and response tracker for one clos ingress node. Each cycle it maps up to NumIn requesting inputs onto distinct free middle-stage ports (ClosM), with rotating priority on both inputs and middle ports. It drives the select lines for the node's request and response muxes, and records each granted transaction in a fixed-latency delay line so the response from middle port m returns to the input that issued it.

Parameters:
NumIn, 4, inputs per ingress node; 1 <= NumIn <= ClosM.
ClosM, 8, middle-stage ports; power of two.
RespLatency, 2, cycles from grant to response at the middle ports; >= 1.
WriteRespOn, 1, 1 = writes (wen_i=1) also return a response.
InW, max(1,$clog2(NumIn)), derived input-index width.
MidW, max(1,$clog2(ClosM)), derived middle-index width.

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
req_i  in  NumIn  request per input
wen_i  in  NumIn  1 = store, 0 = load
gnt_o  out  NumIn  grant per input, combinational in req_i, mid_avail_i, mid_gnt_i
mid_avail_i  in  ClosM  middle port eligible for allocation this cycle
mid_req_o  out  ClosM  request toward each middle port
mid_in_sel_o  out  ClosM*InW  input index driving middle port m (request mux select)
mid_gnt_i  in  ClosM  grant from each middle port
resp_vld_o  out  NumIn  response valid per input
resp_sel_o  out  NumIn*MidW  middle port carrying the response for input i (response mux select)

Interface:
- One clock, clk_i. Reset rst_ni is synchronous and active-low.

Behaviour:
- State:
  - rr_in: input priority pointer, InW bits.
  - rr_mid: middle search pointer, MidW bits.
  - Delay line: RespLatency stages; each stage holds ClosM x {vld, InW idx}.
- Reset (sampled on clk_i while rst_ni=0):
  - rr_in=0, rr_mid=0, all delay-line vld=0.
  - resp_vld_o=0 and resp_sel_o=0 in the first cycle after reset.
  - Combinational outputs reset to 0 only when req_i=0.
- Allocation (combinational, single pass):
  - Inputs are visited in order rr_in, rr_in+1, ... mod NumIn.
  - Each requesting input claims the first middle port, searching rr_mid, rr_mid+1, ... mod ClosM, that has mid_avail_i=1 and is not yet claimed this cycle.
  - An input finding no free port is not served this cycle.
- Middle-side outputs:
  - Claimed port m: mid_req_o[m]=1 and mid_in_sel_o[m]=claiming input.
  - Unclaimed port: mid_req_o[m]=0 and mid_in_sel_o[m]=0.
- Grant: gnt_o[i] = input i claimed port m AND mid_gnt_i[m].
- Pointer update, only when at least one gnt_o bit is high:
  - rr_in <= rr_in+1 mod NumIn.
  - rr_mid <= (highest-order-claimed port that was granted)+1 mod ClosM. "Highest-order" means last in the search order.
  - Otherwise both pointers hold.
- Response push, at the delay-line head, for each port m with a granted transaction:
  - vld = (wen=0) OR WriteRespOn.
  - idx = input index.
  - Ungranted claims push vld=0.
- Response pop: at the tail, resp_vld_o[i]=1 iff some port m has tail vld=1 with idx=i; resp_sel_o[i]=m. Otherwise resp_sel_o[i]=0.
- Response timing:
  - A grant in cycle t produces resp_vld_o in cycle t+RespLatency.
  - The delay line shifts every cycle; no stall.
- Uniqueness: at most one tail entry per input, because an input holds at most one grant per cycle.
- Boundary cases:
  - All mid_avail_i=0: no grants, pointers hold.
  - req_i=0: mid_req_o=0.
  - Pointer wraps are modulo NumIn and modulo ClosM.
  - Reset asserted mid-flight: all in-flight responses are discarded and never reported.
- Assertions (translate_off):
  - ClosM is a power of two; NumIn <= ClosM; RespLatency >= 1.
  - No two inputs claim the same port.
  - resp_vld_o is onehot per input source port.

Decomposition:
- Shared package clos_pkg holds:
  - Index-width helper functions (idx_width(n) = max(1,$clog2(n))).
  - Typedef of a delay-line entry struct {vld, idx}, parameterised by width via the module.
- Natural sub-module: clos_resp_delay, a RespLatency-deep shift register of ClosM entries with synchronous active-low clear.

Test Plan:
- All benches use NumIn=4, ClosM=8, RespLatency=2, WriteRespOn=1 unless noted.
- Reset: hold rst_ni=0 for 3 cycles with req_i=0 -> all outputs 0; after release, first grant goes input0->port0.
- Full load: req_i=1111, wen_i=0, mid_avail_i=FF, mid_gnt_i=FF -> mid_in_sel ports0..3 = 0,1,2,3; gnt_o=1111; rr_in=1, rr_mid=4. Two cycles later resp_vld_o=1111 with resp_sel_o = 0,1,2,3.
- Scarce ports: pointers 0, req_i=1111, mid_avail_i=00000101 -> input0->port0, input1->port2; gnt_o=0011; mid_req_o=00000101.
- Middle backpressure: same as full load but mid_gnt_i[0]=0 -> gnt_o=1110; no response for input0 at t+2; rr_mid=4.
- Write responses off: WriteRespOn=0, req_i=0001, wen_i=0001 -> gnt_o=0001; resp_vld_o stays 0 for 4 cycles.
- Reset mid-flight: grant 1111 at t; rst_ni=0 at t+1 for 1 cycle -> resp_vld_o=0 in t+2 and t+3; pointers back to 0.

Source files
------------

// File: rtl/clos_pkg.sv
// Shared helpers for the clos ingress-node blocks.
//   idx_width(n) : bits needed to index n items, never less than one.
// Delay-line entries are declared in the modules that own them because
// their index width depends on module parameters.
package clos_pkg;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clos_resp_delay.sv
// Fixed-latency response tracker: a Depth-deep shift register of Ports
// entries {vld, idx}. Stage 0 is loaded from the push lanes every cycle and
// the last stage is presented at the tail. There is no stall; the line
// advances on every clock. A synchronous active-low clear drops every
// in-flight entry.
//
// Ports:
//   clk_i       clock
//   rst_ni      synchronous active-low clear
//   push_vld_i  per-port valid loaded into stage 0
//   push_idx_i  per-port index (Ports*IdxW) loaded into stage 0
//   tail_vld_o  per-port valid leaving the last stage
//   tail_idx_o  per-port index (Ports*IdxW) leaving the last stage
module clos_resp_delay #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Ports = 8,
  parameter int unsigned IdxW  = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [Ports-1:0]      push_vld_i,
  input  logic [Ports*IdxW-1:0] push_idx_i,
  output logic [Ports-1:0]      tail_vld_o,
  output logic [Ports*IdxW-1:0] tail_idx_o
);

  typedef struct packed {
    logic            vld;
    logic [IdxW-1:0] idx;
  } entry_t;

  entry_t [Ports-1:0] stage_q [Depth];
  entry_t [Ports-1:0] stage_d [Depth];

  always_comb begin
    for (int s = 0; s < int'(Depth); s++) begin
      stage_d[s] = '0;
    end
    for (int p = 0; p < int'(Ports); p++) begin
      stage_d[0][p].vld = push_vld_i[p];
      stage_d[0][p].idx = push_idx_i[p*IdxW +: IdxW];
    end
    for (int s = 1; s < int'(Depth); s++) begin
      stage_d[s] = stage_q[s-1];
    end
  end

  always_ff @(posedge clk_i) begin
    for (int s = 0; s < int'(Depth); s++) begin
      if (!rst_ni) begin
        stage_q[s] <= '0;
      end else begin
        stage_q[s] <= stage_d[s];
      end
    end
  end

  always_comb begin
    tail_vld_o = '0;
    tail_idx_o = '0;
    for (int p = 0; p < int'(Ports); p++) begin
      tail_vld_o[p]                = stage_q[Depth-1][p].vld;
      tail_idx_o[p*IdxW +: IdxW]   = stage_q[Depth-1][p].idx;
    end
  end

endmodule

// File: rtl/clos_mid_alloc.sv
// Middle-port allocator and response tracker for one clos ingress node.
// Each cycle up to NumIn requesting inputs are mapped onto distinct free
// middle ports with rotating priority on both sides. Granted transactions
// are recorded in a fixed-latency delay line so that the response arriving
// on middle port m is steered back to the input that issued it.
//
// Handshake: an input transfers in the cycle where req_i[i] and gnt_o[i]
// are both high. gnt_o[i] requires that input i claimed some port m this
// cycle and that port m accepted (mid_gnt_i[m]). A claim without
// mid_gnt_i is dropped and retried by the requester in a later cycle.
//
// Ports:
//   clk_i         clock
//   rst_ni        synchronous active-low reset
//   req_i         request per input
//   wen_i         per input: 1 = store, 0 = load
//   gnt_o         grant per input (combinational)
//   mid_avail_i   middle port eligible for allocation this cycle
//   mid_req_o     request toward each middle port (combinational)
//   mid_in_sel_o  input index driving middle port m (ClosM*InW)
//   mid_gnt_i     grant from each middle port
//   resp_vld_o    response valid per input
//   resp_sel_o    middle port carrying the response for input i (NumIn*MidW)
module clos_mid_alloc
  import clos_pkg::*;
#(
  parameter int unsigned NumIn       = 4,
  parameter int unsigned ClosM       = 8,
  parameter int unsigned RespLatency = 2,
  parameter bit          WriteRespOn = 1'b1,
  parameter int unsigned InW         = idx_width(NumIn),
  parameter int unsigned MidW        = idx_width(ClosM)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NumIn-1:0]       req_i,
  input  logic [NumIn-1:0]       wen_i,
  output logic [NumIn-1:0]       gnt_o,
  input  logic [ClosM-1:0]       mid_avail_i,
  output logic [ClosM-1:0]       mid_req_o,
  output logic [ClosM*InW-1:0]   mid_in_sel_o,
  input  logic [ClosM-1:0]       mid_gnt_i,
  output logic [NumIn-1:0]       resp_vld_o,
  output logic [NumIn*MidW-1:0]  resp_sel_o
);

  logic [InW-1:0]  rr_in_q,  rr_in_d;
  logic [MidW-1:0] rr_mid_q, rr_mid_d;

  logic [ClosM-1:0] claimed;
  logic [InW-1:0]   claim_idx [ClosM];
  logic [NumIn-1:0] in_has;
  logic [MidW-1:0]  in_port [NumIn];
  logic [NumIn-1:0] gnt;

  logic [ClosM-1:0]     push_vld;
  logic [ClosM*InW-1:0] push_idx;
  logic [ClosM-1:0]     tail_vld;
  logic [ClosM*InW-1:0] tail_idx;

  // Single-pass allocation. Inputs are visited from rr_in; each takes the
  // first available, still unclaimed port found searching from rr_mid.
  always_comb begin
    logic [InW-1:0]  ii;
    logic [MidW-1:0] mm;
    logic            found;
    ii      = '0;
    mm      = '0;
    found   = 1'b0;
    claimed = '0;
    in_has  = '0;
    for (int m = 0; m < int'(ClosM); m++) begin
      claim_idx[m] = '0;
    end
    for (int i = 0; i < int'(NumIn); i++) begin
      in_port[i] = '0;
    end
    for (int k = 0; k < int'(NumIn); k++) begin
      ii    = InW'((int'(rr_in_q) + k) % int'(NumIn));
      found = 1'b0;
      if (req_i[ii]) begin
        for (int j = 0; j < int'(ClosM); j++) begin
          // ClosM is a power of two, so the MidW-bit sum wraps modulo ClosM.
          mm = rr_mid_q + MidW'(j);
          if (!found && mid_avail_i[mm] && !claimed[mm]) begin
            claimed[mm]   = 1'b1;
            claim_idx[mm] = ii;
            in_has[ii]    = 1'b1;
            in_port[ii]   = mm;
            found         = 1'b1;
          end
        end
      end
    end
  end

  // Grants and pointer advance. Walking inputs in visit order means the last
  // granted input owns the granted port furthest along the search order.
  always_comb begin
    logic [InW-1:0] ii;
    ii       = '0;
    gnt      = '0;
    rr_in_d  = rr_in_q;
    rr_mid_d = rr_mid_q;
    for (int k = 0; k < int'(NumIn); k++) begin
      ii = InW'((int'(rr_in_q) + k) % int'(NumIn));
      if (in_has[ii] && mid_gnt_i[in_port[ii]]) begin
        gnt[ii]  = 1'b1;
        rr_mid_d = in_port[ii] + MidW'(1);
      end
    end
    if (|gnt) begin
      rr_in_d = InW'((int'(rr_in_q) + 1) % int'(NumIn));
    end
  end

  // Middle-side outputs and delay-line head.
  always_comb begin
    mid_req_o    = claimed;
    mid_in_sel_o = '0;
    push_vld     = '0;
    push_idx     = '0;
    for (int m = 0; m < int'(ClosM); m++) begin
      mid_in_sel_o[m*InW +: InW] = claim_idx[m];
      if (claimed[m] && mid_gnt_i[m]) begin
        push_vld[m]            = !wen_i[claim_idx[m]] || WriteRespOn;
        push_idx[m*InW +: InW] = claim_idx[m];
      end
    end
  end

  assign gnt_o = gnt;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_in_q  <= '0;
      rr_mid_q <= '0;
    end else begin
      rr_in_q  <= rr_in_d;
      rr_mid_q <= rr_mid_d;
    end
  end

  clos_resp_delay #(
    .Depth (RespLatency),
    .Ports (ClosM),
    .IdxW  (InW)
  ) u_resp_delay (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_vld_i (push_vld),
    .push_idx_i (push_idx),
    .tail_vld_o (tail_vld),
    .tail_idx_o (tail_idx)
  );

  // Tail demux: each input holds at most one grant per cycle, so at most one
  // tail entry can target any given input.
  always_comb begin
    logic [InW-1:0] ti;
    ti         = '0;
    resp_vld_o = '0;
    resp_sel_o = '0;
    for (int m = 0; m < int'(ClosM); m++) begin
      ti = tail_idx[m*InW +: InW];
      if (tail_vld[m]) begin
        resp_vld_o[ti]                      = 1'b1;
        resp_sel_o[int'(ti)*MidW +: MidW]   = MidW'(m);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert ((ClosM & (ClosM - 1)) == 0) else $error("ClosM must be a power of two");
      assert (NumIn <= ClosM) else $error("NumIn must not exceed ClosM");
      assert (RespLatency >= 1) else $error("RespLatency must be at least 1");
      for (int a = 0; a < int'(NumIn); a++) begin
        for (int b = a + 1; b < int'(NumIn); b++) begin
          assert (!(in_has[a] && in_has[b] && in_port[a] == in_port[b]))
            else $error("two inputs claimed the same middle port");
        end
      end
      for (int a = 0; a < int'(ClosM); a++) begin
        for (int b = a + 1; b < int'(ClosM); b++) begin
          assert (!(tail_vld[a] && tail_vld[b] &&
                    tail_idx[a*InW +: InW] == tail_idx[b*InW +: InW]))
            else $error("two responses target the same input");
        end
      end
    end
  end

endmodule
